line_clear_engine: RTL

//  Post-lock line-clear sequencer for the playfield row-register bank.
//  - Scans rows from bottom to top and finds full rows (every cell nonzero).
//  - Compacts the board downward by rewriting row registers one row per cycle,

---
 rtl/line_clear_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/line_clear_engine.sv
// line_clear_engine: post-lock line-clear sequencer for the playfield row bank.
// Scans rows bottom-up and rewrites each surviving row into its compacted
// position, one row per cycle, over the shared RowOut bus. It then zero-fills
// the vacated top rows and reports how many lines were removed.
//
// Handshake: Start is a single-cycle request that is accepted only in IDLE.
// Busy stays high from the cycle after acceptance until Done, inclusive.
// Done is a single-cycle completion strobe. LinesCleared updates at the
// clock edge that ends the Done cycle. LoadRow/RowOut form a one-hot write
// command that the bank captures at the end of the same cycle.
module line_clear_engine #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 4,
  parameter int CNTW = 5
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [ROWS*COLS*CW-1:0]  Board,
  output logic [ROWS-1:0]          LoadRow,
  output logic [COLS*CW-1:0]       RowOut,
  output logic                     Busy,
  output logic                     Done,
  output logic [CNTW-1:0]          LinesCleared,
  output logic [15:0]              TotalLines,
  output logic [1:0]               DbgState
);

  localparam int RW = COLS * CW;
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   src_q, src_d;
  logic [IW-1:0]   dst_q, dst_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] lines_q, lines_d;
  logic [15:0]     total_q, total_d;

  logic [RW-1:0]   cur_row;
  logic            row_full;
  logic            scan_write;
  logic [16:0]     total_sum;
  logic [ROWS-1:0] load_raw;

  // Select the row currently addressed by src from the flattened board
  always_comb begin
    cur_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (src_q == IW'(r)) cur_row = Board[r*RW +: RW];
    end
  end

  // A row is full when no cell holds the empty colour code
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (cur_row[c*CW +: CW] == '0) row_full = 1'b0;
    end
  end

  // A surviving row only needs rewriting once a gap has opened below it
  assign scan_write = (state_q == S_SCAN) && !row_full && (src_q != dst_q);
  assign total_sum  = {1'b0, total_q} + 17'(cnt_q);

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; SCAN always covers every row, FILL ends on row 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start) state_d = S_SCAN;
      S_SCAN: if (src_q == '0) state_d = (cnt_d != '0) ? S_FILL : S_DONE;
      S_FILL: if (dst_q == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: row pointers, line counter and statistics
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    total_d = total_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          src_d = IW'(ROWS - 1);
          dst_d = IW'(ROWS - 1);
          cnt_d = '0;
        end
      end
      S_SCAN: begin
        src_d = src_q - 1'b1;
        if (row_full) cnt_d = cnt_q + 1'b1;
        else          dst_d = dst_q - 1'b1;
      end
      S_FILL: dst_d = dst_q - 1'b1;
      S_DONE: begin
        lines_d = cnt_q;
        total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      total_q <= '0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      total_q <= total_d;
    end
  end

  // Mealy write command to the bank; reset blocks writes immediately
  always_comb begin
    load_raw = '0;
    RowOut   = '0;
    LoadRow  = '0;
    case (state_q)
      S_SCAN: begin
        if (scan_write) begin
          load_raw[dst_q] = 1'b1;
          RowOut          = cur_row;
        end
      end
      S_FILL:  load_raw[dst_q] = 1'b1;
      default: ;
    endcase
    if (Reset) LoadRow = load_raw;
  end

  // Status outputs
  always_comb begin
    Busy         = (state_q != S_IDLE);
    Done         = (state_q == S_DONE);
    LinesCleared = lines_q;
    TotalLines   = total_q;
    DbgState     = state_q;
  end

endmodule
